// File: rtl/vga_if.sv
// VGA timing/colour bundle passed between draw-chain stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_layers.sv
// N-layer sprite compositor: three-stage pipeline (address, ROM fetch, select)
// with per-layer attributes shadowed at the start of vertical blanking.
module draw_sprite_layers #(
    parameter int          N_LAYERS   = 4,
    parameter int          SPR_W      = 64,
    parameter int          SPR_H      = 64,
    parameter int          ADDR_W     = 12,
    parameter logic [11:0] TRANSP_KEY = 12'h000
) (
    input  logic                       clk,
    input  logic                       rst,
    vga_if.slave                       vga_in,
    vga_if.master                      vga_out,
    input  logic [N_LAYERS*10-1:0]     layer_x,
    input  logic [N_LAYERS*10-1:0]     layer_y,
    input  logic [N_LAYERS-1:0]        layer_en,
    input  logic [N_LAYERS-1:0]        layer_flip,
    output logic [N_LAYERS*ADDR_W-1:0] rom_addr,
    input  logic [N_LAYERS*12-1:0]     rom_data
);

    // Linear sprite ROM address; the product is formed wide, then truncated.
    function automatic logic [ADDR_W-1:0] sprite_addr(input logic [10:0] row,
                                                      input logic [10:0] col);
        int signed lin;
        lin = int'(row) * SPR_W + int'(col);
        return lin[ADDR_W-1:0];
    endfunction

    logic [9:0]          sh_x [N_LAYERS];
    logic [9:0]          sh_y [N_LAYERS];
    logic [N_LAYERS-1:0] sh_en;
    logic [N_LAYERS-1:0] sh_flip;
    logic                vblnk_prev;

    logic [N_LAYERS-1:0] hit_c;
    logic [ADDR_W-1:0]   addr_c [N_LAYERS];

    logic [N_LAYERS-1:0] hit_p0, hit_p1;
    logic                hsync_p0, hblnk_p0, vsync_p0, vblnk_p0;
    logic                hsync_p1, hblnk_p1, vsync_p1, vblnk_p1;
    logic [10:0]         hcount_p0, vcount_p0, hcount_p1, vcount_p1;
    logic [11:0]         rgb_p0, rgb_p1;
    logic [11:0]         rgb_sel;

    // Shadow attributes load only on the rising edge of vblnk so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            sh_en      <= '0;
            sh_flip    <= '0;
            for (int i = 0; i < N_LAYERS; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
            end
        end else begin
            vblnk_prev <= vga_in.vblnk;
            if (vga_in.vblnk && !vblnk_prev) begin
                sh_en   <= layer_en;
                sh_flip <= layer_flip;
                for (int i = 0; i < N_LAYERS; i++) begin
                    sh_x[i] <= layer_x[10*i +: 10];
                    sh_y[i] <= layer_y[10*i +: 10];
                end
            end
        end
    end

    // Stage 1: per-layer hit test and ROM address, 11-bit compares so x+SPR_W cannot wrap.
    always_comb begin
        logic [10:0] x11, y11, col, row;
        x11 = '0;
        y11 = '0;
        col = '0;
        row = '0;
        hit_c = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            x11 = {1'b0, sh_x[i]};
            y11 = {1'b0, sh_y[i]};
            hit_c[i] = sh_en[i]
                     && (vga_in.hcount >= x11) && (vga_in.hcount < x11 + 11'(SPR_W))
                     && (vga_in.vcount >= y11) && (vga_in.vcount < y11 + 11'(SPR_H));
            col = vga_in.hcount - x11;
            if (sh_flip[i])
                col = 11'(SPR_W - 1) - col;
            row = vga_in.vcount - y11;
            addr_c[i] = hit_c[i] ? sprite_addr(row, col) : '0;
        end
    end

    // Stage 1/2 control registers: ROM address, hit vectors and timing strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            hit_p0   <= '0;
            hit_p1   <= '0;
            {hsync_p0, hblnk_p0, vsync_p0, vblnk_p0} <= '0;
            {hsync_p1, hblnk_p1, vsync_p1, vblnk_p1} <= '0;
        end else begin
            for (int i = 0; i < N_LAYERS; i++)
                rom_addr[ADDR_W*i +: ADDR_W] <= addr_c[i];
            hit_p0 <= hit_c;
            {hsync_p0, hblnk_p0, vsync_p0, vblnk_p0} <=
                {vga_in.hsync, vga_in.hblnk, vga_in.vsync, vga_in.vblnk};
            // Stage 2: ROM returns data while control waits one more clock.
            hit_p1 <= hit_p0;
            {hsync_p1, hblnk_p1, vsync_p1, vblnk_p1} <=
                {hsync_p0, hblnk_p0, vsync_p0, vblnk_p0};
        end
    end

    // Stage 1/2 data registers: counters and background colour ride along unreset.
    always_ff @(posedge clk) begin
        hcount_p0 <= vga_in.hcount;
        vcount_p0 <= vga_in.vcount;
        rgb_p0    <= vga_in.rgb;
        hcount_p1 <= hcount_p0;
        vcount_p1 <= vcount_p0;
        rgb_p1    <= rgb_p0;
    end

    // Stage 3: lowest-index opaque hit wins; blanking always shows the background.
    always_comb begin
        rgb_sel = rgb_p1;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (hit_p1[i] && (rom_data[12*i +: 12] != TRANSP_KEY))
                rgb_sel = rom_data[12*i +: 12];
        end
        if (hblnk_p1 || vblnk_p1)
            rgb_sel = rgb_p1;
    end

    // Output register: everything clears during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= hcount_p1;
            vga_out.vcount <= vcount_p1;
            vga_out.hsync  <= hsync_p1;
            vga_out.hblnk  <= hblnk_p1;
            vga_out.vsync  <= vsync_p1;
            vga_out.vblnk  <= vblnk_p1;
            vga_out.rgb    <= rgb_sel;
        end
    end

endmodule

// File: tb/tb_draw_sprite_layers.sv
// Randomised bench for draw_sprite_layers against a per-pixel reference model.
module tb_draw_sprite_layers;

    localparam int N    = 4;
    localparam int SW   = 64;
    localparam int SH   = 64;
    localparam int AW   = 12;
    localparam int NCYC = 12000;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*10-1:0]   layer_x, layer_y;
    logic [N-1:0]      layer_en, layer_flip;
    logic [N*AW-1:0]   rom_addr;
    logic [N*12-1:0]   rom_data = '0;

    vga_if vin ();
    vga_if vout ();

    draw_sprite_layers #(.N_LAYERS(N), .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW),
                         .TRANSP_KEY(12'h000)) dut (
        .clk(clk), .rst(rst), .vga_in(vin), .vga_out(vout),
        .layer_x(layer_x), .layer_y(layer_y), .layer_en(layer_en),
        .layer_flip(layer_flip), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: every third word is the transparent key.
    function automatic logic [11:0] rom_color(input int layer, input int addr);
        int h;
        if (((addr + layer) % 3) == 0) return 12'h000;
        h = (addr * 37 + layer * 911 + 5) % 4096;
        if (h == 0) h = 1;
        return 12'(h);
    endfunction

    // Registered ROMs with one clock of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            rom_data[12*i +: 12] <= rom_color(i, int'(rom_addr[AW*i +: AW]));
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20)
                $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference state: shadowed attributes and the vblank edge detector.
    int m_x [N];
    int m_y [N];
    bit m_en [N];
    bit m_flip [N];
    bit m_prev;

    // Per-input history of stimulus and expectations.
    bit  h_rst [NCYC];
    int  h_hc  [NCYC];
    int  h_vc  [NCYC];
    int  h_tim [NCYC];
    int  h_rgb [NCYC];
    int  e_rgb [NCYC];
    int  e_addr [NCYC][N];

    function automatic int sprite_addr_model(input int i, input int hc, input int vc);
        int col, row;
        col = hc - m_x[i];
        row = vc - m_y[i];
        if (m_flip[i]) col = SW - 1 - col;
        return (row * SW + col) % (1 << AW);
    endfunction

    function automatic bit inside_sprite(input int i, input int hc, input int vc);
        return m_en[i] && hc >= m_x[i] && hc < m_x[i] + SW
                       && vc >= m_y[i] && vc < m_y[i] + SH;
    endfunction

    function automatic int pixel_model(input int hc, input int vc, input bit hb,
                                       input bit vb, input int bg);
        int c;
        if (hb || vb) return bg;
        for (int i = 0; i < N; i++) begin
            if (inside_sprite(i, hc, vc)) begin
                c = int'(rom_color(i, sprite_addr_model(i, hc, vc)));
                if (c != 0) return c;
            end
        end
        return bg;
    endfunction

    function automatic int pick_x();
        case ($urandom % 4)
            0: return int'($urandom_range(0, 1023));
            1: return 1023;
            2: return 780;
            default: return int'($urandom_range(0, 60));
        endcase
    endfunction

    initial begin
        int vb_cnt, rst_cnt, k, hc, vc;
        bit hs, hb, vs, vb;
        logic [11:0] bg;
        vb_cnt = 0;
        rst_cnt = 0;
        m_prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0; m_flip[i] = 1'b0;
        end
        rst = 1'b1;
        layer_x = '0; layer_y = '0; layer_en = '0; layer_flip = '0;
        vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
        vin.hsync = 1'b0; vin.hblnk = 1'b0; vin.vsync = 1'b0; vin.vblnk = 1'b0;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            cyc = n;
            // Check outputs produced by earlier inputs.
            if (n >= 1) begin
                if (h_rst[n-1]) begin
                    check_eq("rst_rgb", 32'(vout.rgb), 32'h0);
                    check_eq("rst_tim", 32'({vout.hcount, vout.vcount, vout.hsync,
                                             vout.hblnk, vout.vsync, vout.vblnk}), 32'h0);
                    check_eq("rst_addr", 32'(rom_addr), 32'h0);
                end else begin
                    for (int i = 0; i < N; i++)
                        check_eq($sformatf("rom_addr%0d", i),
                                 32'(rom_addr[AW*i +: AW]), 32'(e_addr[n-1][i]));
                    if (n >= 3 && !h_rst[n-2] && !h_rst[n-3]) begin
                        check_eq("rgb", 32'(vout.rgb), 32'(e_rgb[n-3]));
                        check_eq("hcount", 32'(vout.hcount), 32'(h_hc[n-3]));
                        check_eq("vcount", 32'(vout.vcount), 32'(h_vc[n-3]));
                        check_eq("strobes", 32'({vout.hsync, vout.hblnk, vout.vsync,
                                                 vout.vblnk}), 32'(h_tim[n-3]));
                    end
                end
            end

            // Reset: initial hold, plus occasional mid-run pulses.
            if (n < 5) rst = 1'b1;
            else if (rst_cnt > 0) begin rst = 1'b1; rst_cnt--; end
            else if (n > 1000 && ($urandom % 2000) == 0) begin rst = 1'b1; rst_cnt = 1; end
            else rst = 1'b0;

            // Attributes wander at arbitrary times; only vblank start makes them visible.
            if (($urandom % 100) == 0) begin
                k = int'($urandom % N);
                layer_x[10*k +: 10]  = 10'(pick_x());
                layer_y[10*k +: 10]  = 10'(($urandom % 2) ? 0 : $urandom_range(0, 1023));
                layer_en[k]          = ($urandom % 4) != 0;
                layer_flip[k]        = $urandom % 2;
            end

            if (vb_cnt > 0) begin vb = 1'b1; vb_cnt--; end
            else if (($urandom % 150) == 0) begin vb = 1'b1; vb_cnt = int'($urandom_range(0, 3)); end
            else vb = 1'b0;
            hb = ($urandom % 8) == 0;
            hs = $urandom % 2;
            vs = $urandom % 2;
            bg = 12'($urandom);
            k = int'($urandom % N);
            if (($urandom % 10) < 7) begin
                hc = m_x[k] + int'($urandom_range(0, 90)) - 12;
                vc = m_y[k] + int'($urandom_range(0, 80)) - 8;
                if (hc < 0) hc = 0;
                if (vc < 0) vc = 0;
            end else begin
                hc = int'($urandom_range(0, 1100));
                vc = int'($urandom_range(0, 1100));
            end

            vin.hcount = 11'(hc); vin.vcount = 11'(vc); vin.rgb = bg;
            vin.hsync = hs; vin.hblnk = hb; vin.vsync = vs; vin.vblnk = vb;

            // Reference expectations use the shadow as it stands before this edge.
            h_rst[n] = rst;
            h_hc[n]  = hc;
            h_vc[n]  = vc;
            h_tim[n] = int'({hs, hb, vs, vb});
            h_rgb[n] = int'(bg);
            e_rgb[n] = pixel_model(hc, vc, hb, vb, int'(bg));
            for (int i = 0; i < N; i++)
                e_addr[n][i] = inside_sprite(i, hc, vc) ? sprite_addr_model(i, hc, vc) : 0;

            if (rst) begin
                m_prev = 1'b0;
                for (int i = 0; i < N; i++) begin
                    m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0; m_flip[i] = 1'b0;
                end
            end else begin
                if (vb && !m_prev) begin
                    for (int i = 0; i < N; i++) begin
                        m_x[i]    = int'(layer_x[10*i +: 10]);
                        m_y[i]    = int'(layer_y[10*i +: 10]);
                        m_en[i]   = layer_en[i];
                        m_flip[i] = layer_flip[i];
                    end
                end
                m_prev = vb;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
